// File: rtl/reg_file_2r1w.sv
// ============================================================================
// Module      : reg_file_2r1w
// Description : Two-read / one-write register file with an optional hard-wired
//               zero register and selectable registered or combinational reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_2r1w #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 1,
  parameter int REG_READ = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    ra0,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1
);

  localparam logic c_ZERO_EN = (ZERO_REG != 0);

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_wr_zero;
  logic             w_wr_en;
  logic             w_rd0_zero;
  logic             w_rd1_zero;
  logic [WIDTH-1:0] w_rd0_mem;
  logic [WIDTH-1:0] w_rd1_mem;

  assign w_wr_zero  = c_ZERO_EN && (waddr == '0);
  assign w_wr_en    = we && !w_wr_zero;
  assign w_rd0_zero = c_ZERO_EN && (ra0 == '0);
  assign w_rd1_zero = c_ZERO_EN && (ra1 == '0);
  assign w_rd0_mem  = w_rd0_zero ? '0 : r_mem[ra0];
  assign w_rd1_mem  = w_rd1_zero ? '0 : r_mem[ra1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[waddr] <= wdata;
    end
  end

  generate
    if (REG_READ != 0) begin : g_reg_read
      logic             w_byp0;
      logic             w_byp1;
      logic [WIDTH-1:0] r_rd0;
      logic [WIDTH-1:0] r_rd1;

      // A discarded zero-register write never bypasses, so address 0 still loads zero.
      assign w_byp0 = w_wr_en && (waddr == ra0);
      assign w_byp1 = w_wr_en && (waddr == ra1);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rd0 <= '0;
          r_rd1 <= '0;
        end else begin
          r_rd0 <= w_byp0 ? wdata : w_rd0_mem;
          r_rd1 <= w_byp1 ? wdata : w_rd1_mem;
        end
      end

      assign rd0 = r_rd0;
      assign rd1 = r_rd1;
    end else begin : g_comb_read
      assign rd0 = w_rd0_mem;
      assign rd1 = w_rd1_mem;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
// ============================================================================
// Module      : tb_reg_file_2r1w
// Description : Directed self-checking bench for reg_file_2r1w (registered
//               default instance plus a 16x32 combinational-read instance).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_2r1w;

  logic        clk;
  logic        rst;

  logic        a_we;
  logic [2:0]  a_waddr;
  logic [7:0]  a_wdata;
  logic [2:0]  a_ra0;
  logic [2:0]  a_ra1;
  logic [7:0]  a_rd0;
  logic [7:0]  a_rd1;

  logic        b_we;
  logic [4:0]  b_waddr;
  logic [15:0] b_wdata;
  logic [4:0]  b_ra0;
  logic [4:0]  b_ra1;
  logic [15:0] b_rd0;
  logic [15:0] b_rd1;

  int n_checks;
  int n_errors;

  reg_file_2r1w u_dut_a (
    .clk   (clk),
    .rst   (rst),
    .we    (a_we),
    .waddr (a_waddr),
    .wdata (a_wdata),
    .ra0   (a_ra0),
    .ra1   (a_ra1),
    .rd0   (a_rd0),
    .rd1   (a_rd1)
  );

  reg_file_2r1w #(
    .WIDTH    (16),
    .DEPTH    (32),
    .ZERO_REG (1),
    .REG_READ (0)
  ) u_dut_b (
    .clk   (clk),
    .rst   (rst),
    .we    (b_we),
    .waddr (b_waddr),
    .wdata (b_wdata),
    .ra0   (b_ra0),
    .ra1   (b_ra1),
    .rd0   (b_rd0),
    .rd1   (b_rd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, so every check is away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] e0;
    logic [7:0] e1;
    n_checks = 0;
    n_errors = 0;
    rst     = 1'b1;
    a_we = 1'b0; a_waddr = '0; a_wdata = '0; a_ra0 = '0; a_ra1 = '0;
    b_we = 1'b0; b_waddr = '0; b_wdata = '0; b_ra0 = '0; b_ra1 = '0;

    tick();
    check("reset_rd0", {8'h0, a_rd0}, 16'h0000);
    check("reset_rd1", {8'h0, a_rd1}, 16'h0000);
    rst = 1'b0;

    // r3 = A5, then asynchronous reset between edges
    a_we = 1'b1; a_waddr = 3'd3; a_wdata = 8'hA5; a_ra0 = 3'd3;
    tick();
    check("wr3_bypass", {8'h0, a_rd0}, 16'h00A5);
    a_we = 1'b0;
    tick();
    check("wr3_stored", {8'h0, a_rd0}, 16'h00A5);
    a_we = 1'b1; a_waddr = 3'd6; a_wdata = 8'h77;
    #3 rst = 1'b1;
    #1 check("async_rst_rd0", {8'h0, a_rd0}, 16'h0000);
    tick();
    check("rst_held_rd0", {8'h0, a_rd0}, 16'h0000);
    #2 rst = 1'b0; a_we = 1'b0; a_ra0 = 3'd3; a_ra1 = 3'd6;
    tick();
    check("r3_after_rst", {8'h0, a_rd0}, 16'h0000);
    check("r6_write_in_rst", {8'h0, a_rd1}, 16'h0000);

    // basic write r5 = 3C, read on port 1
    a_we = 1'b1; a_waddr = 3'd5; a_wdata = 8'h3C; a_ra1 = 3'd5; a_ra0 = 3'd4;
    tick();
    check("r5_bypass_rd1", {8'h0, a_rd1}, 16'h003C);
    check("r4_no_bypass", {8'h0, a_rd0}, 16'h0000);
    a_we = 1'b0; a_wdata = 8'hFF;
    tick();
    check("r5_stored", {8'h0, a_rd1}, 16'h003C);
    tick();
    check("r5_we0_hold", {8'h0, a_rd1}, 16'h003C);

    // bypass on both ports over an older value
    a_we = 1'b1; a_waddr = 3'd2; a_wdata = 8'h11; a_ra0 = 3'd5; a_ra1 = 3'd5;
    tick();
    a_wdata = 8'h22; a_ra0 = 3'd2; a_ra1 = 3'd2;
    tick();
    check("byp_rd0", {8'h0, a_rd0}, 16'h0022);
    check("byp_rd1", {8'h0, a_rd1}, 16'h0022);
    a_we = 1'b0;
    tick();
    check("r2_rd0", {8'h0, a_rd0}, 16'h0022);
    check("r2_rd1", {8'h0, a_rd1}, 16'h0022);

    // zero register
    a_we = 1'b1; a_waddr = 3'd0; a_wdata = 8'hFF; a_ra0 = 3'd0;
    tick();
    check("zero_same_cycle", {8'h0, a_rd0}, 16'h0000);
    a_we = 1'b0;
    tick();
    check("zero_later", {8'h0, a_rd0}, 16'h0000);

    // fill sweep, then read mirrored pairs
    for (int i = 0; i < 8; i++) begin
      a_we = 1'b1; a_waddr = i[2:0]; a_wdata = 8'(i * 8'h11);
      tick();
    end
    a_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_ra0 = i[2:0];
      a_ra1 = 3'(7 - i);
      e0 = (i == 0) ? 8'h00 : 8'(i * 8'h11);
      e1 = (i == 7) ? 8'h00 : 8'((7 - i) * 8'h11);
      tick();
      check($sformatf("sweep_rd0_%0d", i), {8'h0, a_rd0}, {8'h0, e0});
      check($sformatf("sweep_rd1_%0d", i), {8'h0, a_rd1}, {8'h0, e1});
    end

    // combinational-read instance: no bypass, update visible after the edge
    b_ra0 = 5'd31; b_ra1 = 5'd0;
    #1 check("comb_r31_init", b_rd0, 16'h0000);
    b_we = 1'b1; b_waddr = 5'd31; b_wdata = 16'h1234;
    #1 check("comb_no_bypass0", b_rd0, 16'h0000);
    tick();
    check("comb_r31_1234", b_rd0, 16'h1234);
    b_wdata = 16'hBEEF;
    #1 check("comb_before_edge", b_rd0, 16'h1234);
    tick();
    check("comb_after_edge", b_rd0, 16'hBEEF);
    b_waddr = 5'd0; b_wdata = 16'hFFFF; b_ra1 = 5'd0;
    tick();
    check("comb_zero_reg", b_rd1, 16'h0000);
    b_we = 1'b0; b_ra1 = 5'd31;
    #1 check("comb_same_reg", b_rd1, 16'hBEEF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_file_2r1w.md
REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of every register and port.
REQ-002 SHALL have parameter DEPTH, default 8, register count; legal values are powers of two, 2 to 256.
REQ-003 SHALL have derived parameter AW = log2(DEPTH), default 3, address width; not user-overridable.
REQ-004 SHALL have parameter ZERO_REG, default 1; when 1, register 0 is hard-wired to zero.
REQ-005 SHALL have parameter REG_READ, default 1; 1 = registered read outputs, 0 = combinational read outputs.
REQ-006 SHALL use one clock and an asynchronous, active-high reset, named clk and rst.
REQ-007 port: clk  input  1  rising-edge clock for all state.
REQ-008 port: rst  input  1  asynchronous active-high reset.
REQ-009 port: we  input  1  write enable, sampled at rising clk.
REQ-010 port: waddr  input  AW  write address.
REQ-011 port: wdata  input  WIDTH  write data.
REQ-012 port: ra0  input  AW  read address, port 0.
REQ-013 port: ra1  input  AW  read address, port 1.
REQ-014 port: rd0  output  WIDTH  read data, port 0.
REQ-015 port: rd1  output  WIDTH  read data, port 1.

Function
REQ-016 SHALL hold DEPTH registers of WIDTH bits; register[waddr] <= wdata at rising clk when we=1 and rst=0.
REQ-017 SHALL leave every register unchanged when we=0.
REQ-018 With ZERO_REG=1: writes to address 0 SHALL be discarded; reads of address 0 SHALL return all-zeros on either port.
REQ-019 With REG_READ=1: at each rising clk, rd0/rd1 SHALL load the content addressed by ra0/ra1; read latency exactly 1 cycle.
REQ-020 With REG_READ=1: if we=1 and waddr equals a read address in the same cycle, that port SHALL load wdata (write-through bypass), except address 0 when ZERO_REG=1, which loads zero.
REQ-021 With REG_READ=0: rd0/rd1 SHALL combinationally reflect current stored content of ra0/ra1; a same-cycle write is visible only after the rising edge (no bypass).
REQ-022 Both ports addressing the same register SHALL return identical data in the same cycle.
REQ-023 Write and two reads SHALL be fully concurrent; no stalls, no handshake, no port priority.
REQ-024 Every address value 0..DEPTH-1 is legal; there is no out-of-range condition.

Reset
REQ-025 rst=1 SHALL immediately (without clk) clear all registers to 0, and rd0/rd1 to 0 when REG_READ=1.
REQ-026 While rst=1, writes SHALL be ignored and rd0/rd1 SHALL read 0.
REQ-027 First write SHALL take effect on the first rising clk with rst=0; reset asserted mid-write SHALL leave the target register 0.

Verification
REQ-028 Reset: write 8'hA5 to r3, assert rst between edges -> rd0 (ra0=3) reads 8'h00 before next clk; r3 reads 8'h00 after release.
REQ-029 Basic write/read (defaults): we=1, waddr=5, wdata=8'h3C at edge N; ra1=5 -> rd1=8'h3C after edge N+1 (after edge N with bypass, see REQ-030).
REQ-030 Bypass (REG_READ=1): r2=8'h11 stored; same cycle we=1, waddr=2, wdata=8'h22, ra0=ra1=2 -> after edge rd0=rd1=8'h22.
REQ-031 Zero register (ZERO_REG=1): we=1, waddr=0, wdata=8'hFF; ra0=0 -> rd0=8'h00 then and all later cycles.
REQ-032 Combinational mode (REG_READ=0, WIDTH=16, DEPTH=32): r31=16'h1234; write 16'hBEEF to r31 with ra0=31 -> rd0=16'h1234 before edge, 16'hBEEF after.
REQ-033 Fill sweep: write r(i)=i*8'h11 for i=0..7, read all pairs (ra0=i, ra1=7-i) -> expected values, r0=0 with ZERO_REG=1.
